// File: rtl/i2s_sample_fifo.sv
// Stereo {left,right} sample FIFO with show-ahead valid/ready output and sticky overflow.
// Define I2S_FIFO_OVF_CNT_EN to build the saturating dropped-pair counter on ovf_cnt_o.
module i2s_sample_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = 24
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [DW-1:0]              left_i,
  input  logic [DW-1:0]              right_i,
  input  logic                       in_strobe_i,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic [DW-1:0]              m_left_o,
  output logic [DW-1:0]              m_right_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       overflow_o,
  input  logic                       clr_ovf_i,
  output logic [15:0]                ovf_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam logic [AW:0]   PtrOne = {{AW{1'b0}}, 1'b1};
  localparam logic [LW-1:0] LvlOne = {{(LW-1){1'b0}}, 1'b1};

  logic [2*DW-1:0] mem_q [DEPTH];

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;

  logic empty, full, push, pop, drop;
  logic [2*DW-1:0] head;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && m_ready_i;
  // A same-cycle pop frees the head slot, so a full FIFO can still take the new pair.
  assign push  = in_strobe_i && (!full || pop);
  assign drop  = in_strobe_i && full && !pop;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
    if (push && !pop)      level_d = level_q + LvlOne;
    else if (pop && !push) level_d = level_q - LvlOne;
    if (drop)           ovf_d = 1'b1;
    else if (clr_ovf_i) ovf_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is deliberately not reset; pointer reset alone discards contents.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {left_i, right_i};
  end

  always_comb begin
    m_valid_o = !empty;
    m_left_o  = '0;
    m_right_o = '0;
    if (!empty) begin
      m_left_o  = head[2*DW-1:DW];
      m_right_o = head[DW-1:0];
    end
  end

  assign level_o    = level_q;
  assign overflow_o = ovf_q;

`ifdef I2S_FIFO_OVF_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_ovf_i)                    cnt_d = drop ? 16'd1 : 16'd0;
    else if (drop && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign ovf_cnt_o = cnt_q;
`else
  assign ovf_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_i2s_sample_fifo.sv
// Directed self-checking bench for i2s_sample_fifo (DEPTH=16, DW=24).
module tb_i2s_sample_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] left, right;
  logic        strobe, ready, clr_ovf;
  logic        valid, ovf;
  logic [23:0] m_left, m_right;
  logic [4:0]  level;
  logic [15:0] ovf_cnt;

  int checks = 0;
  int errors = 0;

`ifdef I2S_FIFO_OVF_CNT_EN
  localparam logic [15:0] CntOne = 16'd1;
`else
  localparam logic [15:0] CntOne = 16'd0;
`endif

  i2s_sample_fifo #(.DEPTH(16), .DW(24)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .left_i     (left),
    .right_i    (right),
    .in_strobe_i(strobe),
    .m_valid_o  (valid),
    .m_ready_i  (ready),
    .m_left_o   (m_left),
    .m_right_o  (m_right),
    .level_o    (level),
    .overflow_o (ovf),
    .clr_ovf_i  (clr_ovf),
    .ovf_cnt_o  (ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Push n pairs L=R=base+i on consecutive cycles, no pop.
  task automatic fill(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      left = 24'(base + i); right = 24'(base + i); strobe = 1'b1;
      step();
    end
    strobe = 1'b0;
  endtask

  // Pop n pairs with ready=1, expecting heads first..first+n-1.
  task automatic drain(input string tag, input int first, input int n);
    ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check({tag, "_valid"}, 32'(valid), 32'd1);
      check({tag, "_left"},  32'(m_left), 32'(first + i));
      check({tag, "_right"}, 32'(m_right), 32'(first + i));
      step();
    end
    ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; left = '0; right = '0; strobe = 1'b0; ready = 1'b0; clr_ovf = 1'b0;
    repeat (3) step();
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ovf",   32'(ovf), 32'd0);
    check("rst_left",  32'(m_left), 32'd0);
    check("rst_cnt",   32'(ovf_cnt), 32'd0);
    rst_n = 1'b1;
    step();

    // Single pair, show-ahead latency of one edge.
    left = 24'h123456; right = 24'hABCDEF; strobe = 1'b1;
    step();
    strobe = 1'b0;
    check("one_valid", 32'(valid), 32'd1);
    check("one_left",  32'(m_left), 32'h123456);
    check("one_right", 32'(m_right), 32'hABCDEF);
    check("one_level", 32'(level), 32'd1);
    step();
    check("one_stall_left", 32'(m_left), 32'h123456);
    ready = 1'b1;
    step();
    ready = 1'b0;
    check("one_pop_valid", 32'(valid), 32'd0);
    check("one_pop_level", 32'(level), 32'd0);
    check("one_pop_left0", 32'(m_left), 32'd0);

    // Fill and ordered drain.
    fill(0, 16);
    check("fill_level", 32'(level), 32'd16);
    drain("fill", 0, 16);
    check("fill_empty", 32'(valid), 32'd0);
    check("fill_level0", 32'(level), 32'd0);

    // Overflow: 17th pair dropped.
    fill(0, 16);
    left = 24'd99; right = 24'd99; strobe = 1'b1;
    step();
    strobe = 1'b0;
    check("ovf_flag",  32'(ovf), 32'd1);
    check("ovf_cnt",   32'(ovf_cnt), 32'(CntOne));
    check("ovf_level", 32'(level), 32'd16);
    drain("ovf", 0, 16);
    check("ovf_empty", 32'(valid), 32'd0);
    check("ovf_still_set", 32'(ovf), 32'd1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("ovf_clr", 32'(ovf), 32'd0);
    check("ovf_clr_cnt", 32'(ovf_cnt), 32'd0);

    // Full with simultaneous push and pop.
    fill(0, 16);
    left = 24'd50; right = 24'd50; strobe = 1'b1; ready = 1'b1;
    step();
    strobe = 1'b0;
    check("pp_ovf",   32'(ovf), 32'd0);
    check("pp_level", 32'(level), 32'd16);
    drain("pp", 1, 15);
    drain("pp_last", 50, 1);
    check("pp_empty", 32'(valid), 32'd0);

    // Drop coinciding with clear: set wins.
    fill(100, 16);
    left = 24'd77; right = 24'd77; strobe = 1'b1; clr_ovf = 1'b1;
    step();
    strobe = 1'b0; clr_ovf = 1'b0;
    check("setwin_ovf", 32'(ovf), 32'd1);
    check("setwin_cnt", 32'(ovf_cnt), 32'(CntOne));
    drain("setwin", 100, 16);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;

    // Reset mid-operation.
    fill(200, 5);
    check("mid_level5", 32'(level), 32'd5);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_level0", 32'(level), 32'd0);
    check("mid_valid0", 32'(valid), 32'd0);
    left = 24'h55AA55; right = 24'h0F0F0F; strobe = 1'b1;
    step();
    strobe = 1'b0;
    check("mid_valid", 32'(valid), 32'd1);
    check("mid_left",  32'(m_left), 32'h55AA55);
    check("mid_right", 32'(m_right), 32'h0F0F0F);
    check("mid_level", 32'(level), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
